serial_digit_rx: RTL and testbench
==================================

// Module: serial_digit_rx
// PURPOSE
//  Display-side receiver for the serial digit link: deserialises 32-bit digit frames
//  (sclk / data_enable / sdo, MSB first) into a latched 4x8-bit segment register.
//  Scans the register onto a multiplexed 7-seg+DP display. Flags short/long frames.
// PARAMETERS
//  FRAME_BITS   32    bits per valid frame (= DIGITS*SEG_W)
//  DIGITS       4     number of display digits
//  SEG_W        8     bits per digit: {dp,g,f,e,d,c,b,a}
//  SCAN_DIV     2048  clk cycles per digit in the display scan
//  SYNC_STAGES  2     synchroniser depth on ser_* inputs (>=2)
// PORTS
//  clk          in   1           system clock; all logic on posedge
//  rst_n        in   1           synchronous active-low reset
//  ser_sclk     in   1           serial clock, async to clk
//  ser_en       in   1           data enable, high for the whole frame, async
//  ser_sdi      in   1           serial data, sampled on ser_sclk rise, async
//  digits       out  FRAME_BITS  last valid frame; [31:24] = first byte = digit 3
//  frame_valid  out  1           1-clk pulse: digits just updated
//  frame_err    out  1           1-clk pulse: frame ended with bit count != FRAME_BITS
//  seg_out      out  SEG_W       segment bits of the currently selected digit
//  dig_sel      out  DIGITS      one-hot digit enable, active high
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): digits=0, frame_valid=0, frame_err=0, seg_out=0,
//   dig_sel=4'b0001; shift reg, bit count, scan counter, sync flops cleared.
//   Reset mid-frame discards the partial frame; digits is not updated.
//  Input path: each ser_* passes through SYNC_STAGES flops; s_sclk_d holds the previous
//   synced sclk; sclk_rise = s_sclk & ~s_sclk_d; en_rise/en_fall likewise on s_en.
//  Link constraint: ser_sclk high and low phases each >= SYNC_STAGES+2 clk periods.
//  Receive FSM, states IDLE, SHIFT:
//   IDLE : count=0; on en_rise -> SHIFT.
//   SHIFT: on sclk_rise with s_en=1: shreg <= {shreg[FRAME_BITS-2:0], s_sdi};
//          count++ saturating at FRAME_BITS+1 (overrun marker).
//          On en_fall -> IDLE. In that same cycle:
//            count==FRAME_BITS -> digits<=shreg, frame_valid=1 next cycle.
//            otherwise (short, zero or overrun) -> frame_err=1 next cycle; digits held.
//  Simultaneous sclk_rise and en_fall: en_fall wins and the edge is not shifted.
//  Bits after the 32nd set the overrun marker. The frame errors on en_fall.
//  An sclk_rise in IDLE is ignored. Back-to-back frames need en low >= 1 synced sample.
//  Latency: ser_en falling pin edge -> frame_valid high = SYNC_STAGES+2 clk.
//  frame_valid and frame_err are never high together.
//  Scan: counter 0..SCAN_DIV-1, wraps. On wrap, dig_sel rotates left (0001->0010->
//   0100->1000->0001). seg_out is registered: digits slice of the selected digit.
//   digit k = digits[SEG_W*k +: SEG_W]. Update visible on the next clk after digits changes.
// STRUCTURE
//  Shared include serial_digit_defs.vh: FRAME_BITS, SEG_W, DIGITS defaults, FSM state
//   encodings (IDLE=1'b0, SHIFT=1'b1). The same file is used by the digit_spi transmitter.
//  Sub-module sync_edge #(SYNC_STAGES): synchroniser plus rise/fall detect, one instance
//   per ser_* input. FSM, shift register and scan stay in this module.
// TESTING (bench clk 48 MHz, sclk = clk/512 as in the system)
//  1 Frame 32'hA5C3_0F81, en high 32 sclk, MSB first -> one frame_valid pulse; digits=A5C30F81.
//    frame_err stays 0.
//  2 Short frame, 31 bits of 32'hFFFF_FFFF after valid 12345678 -> frame_err pulse;
//    digits stays 12345678.
//  3 Long frame, 33 bits -> frame_err pulse, digits unchanged; en pulse with 0 bits -> frame_err.
//  4 Assert rst_n=0 for 1 clk at bit 16, then a full frame 32'h0000_00FF -> after the reset
//    all outputs are at reset values; then frame_valid, digits=000000FF, no error.
//  5 Scan with SCAN_DIV=4, digits=11223344 -> dig_sel 0001/0010/0100/1000, 4 clk each.
//    seg_out = 44/33/22/11 in that order, then wraps to 0001.
//  6 Drop en on the same clk as the 32nd sclk rise (synced) -> 31 bits counted, frame_err.
//    The next correct frame is accepted.

Source files
------------

// File: rtl/serial_digit_rx_pkg.sv
// Shared constants and types for the serial digit link receiver.
// Default frame geometry and receive FSM encoding.
package serial_digit_rx_pkg;

    // Default link geometry: four digits of {dp,g,f,e,d,c,b,a}.
    localparam int DEF_DIGITS      = 4;
    localparam int DEF_SEG_W       = 8;
    localparam int DEF_FRAME_BITS  = DEF_DIGITS * DEF_SEG_W;
    localparam int DEF_SCAN_DIV    = 2048;
    localparam int DEF_SYNC_STAGES = 2;

    // Receive FSM encoding; the transmitter side uses the same values.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/serial_digit_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input.
// Also flags the rising and falling edges of the synchronised level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;
    logic              prev_q;
    logic              prev_d;

    // Shift the raw input down the chain; remember the last synced level.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], async_i};
        prev_d  = chain_q[STAGES-1];
    end

    // Chain and history flops, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/serial_digit_rx.sv
// Serial digit link receiver: deserialises 32-bit frames into a
// latched segment register and scans it onto a multiplexed display.
module serial_digit_rx
    import serial_digit_rx_pkg::*;
#(
    parameter int FRAME_BITS  = DEF_FRAME_BITS,
    parameter int DIGITS      = DEF_DIGITS,
    parameter int SEG_W       = DEF_SEG_W,
    parameter int SCAN_DIV    = DEF_SCAN_DIV,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ser_sclk,
    input  logic                  ser_en,
    input  logic                  ser_sdi,
    output logic [FRAME_BITS-1:0] digits,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [SEG_W-1:0]      seg_out,
    output logic [DIGITS-1:0]     dig_sel
);

    // Count reaches FRAME_BITS+1 as an overrun marker.
    localparam int CNT_W  = $clog2(FRAME_BITS + 2);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_OVR  = CNT_W'(FRAME_BITS + 1);
    localparam logic [SCAN_W-1:0] SCAN_TOP = SCAN_W'(SCAN_DIV - 1);

    logic s_sclk, sclk_rise, sclk_fall;
    logic s_en, en_rise, en_fall;
    logic s_sdi, sdi_rise, sdi_fall;
    logic unused_edges;

    rx_state_e state_q, state_d;

    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FRAME_BITS-1:0] digits_q, digits_d;
    logic                  valid_pend_q, valid_pend_d;
    logic                  err_pend_q, err_pend_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_err_q, frame_err_d;

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic [SEG_W-1:0]  seg_out_q, seg_out_d;
    logic              scan_wrap;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (ser_sclk),
        .sync_o  (s_sclk),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_en (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (ser_en),
        .sync_o  (s_en),
        .rise_o  (en_rise),
        .fall_o  (en_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (ser_sdi),
        .sync_o  (s_sdi),
        .rise_o  (sdi_rise),
        .fall_o  (sdi_fall)
    );

    // Edge flags this block has no use for.
    assign unused_edges = ^{s_sclk, sclk_fall, sdi_rise, sdi_fall};

    // Receive FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Receive FSM next state: enable edges frame the transfer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en_rise) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (en_fall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Receive datapath: shift bits in, judge the frame on enable fall.
    // en_fall implies s_en=0, so a coincident sclk edge is never shifted.
    always_comb begin
        shreg_d      = shreg_q;
        count_d      = count_q;
        digits_d     = digits_q;
        valid_pend_d = 1'b0;
        err_pend_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
            end
            ST_SHIFT: begin
                if (en_fall) begin
                    count_d = '0;
                    if (count_q == CNT_FULL) begin
                        digits_d     = shreg_q;
                        valid_pend_d = 1'b1;
                    end else begin
                        err_pend_d = 1'b1;
                    end
                end else if (sclk_rise && s_en) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], s_sdi};
                    if (count_q != CNT_OVR) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: count_d = '0;
        endcase
        // Status pulses trail the digits update by one clock.
        frame_valid_d = valid_pend_q;
        frame_err_d   = err_pend_q;
    end

    // Receive datapath and status flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q       <= '0;
            count_q       <= '0;
            digits_q      <= '0;
            valid_pend_q  <= 1'b0;
            err_pend_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            shreg_q       <= shreg_d;
            count_q       <= count_d;
            digits_q      <= digits_d;
            valid_pend_q  <= valid_pend_d;
            err_pend_q    <= err_pend_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Display scan: rotate the digit enable each SCAN_DIV clocks and
    // fetch the matching byte so seg_out and dig_sel change together.
    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_TOP);
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        dig_sel_d  = dig_sel_q;
        if (scan_wrap) begin
            dig_sel_d = {dig_sel_q[DIGITS-2:0], dig_sel_q[DIGITS-1]};
        end
        seg_out_d = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_sel_d[k]) seg_out_d = digits_q[SEG_W*k +: SEG_W];
        end
    end

    // Display scan flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            dig_sel_q  <= DIGITS'(1);
            seg_out_q  <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            dig_sel_q  <= dig_sel_d;
            seg_out_q  <= seg_out_d;
        end
    end

    assign digits      = digits_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign seg_out     = seg_out_q;
    assign dig_sel     = dig_sel_q;

endmodule

// File: tb/tb_serial_digit_rx.sv
// Scoreboard bench for serial_digit_rx: stimulus queues expected frame
// results, a monitor pops them on each frame_valid/frame_err pulse.
module tb_serial_digit_rx;

    // sclk is run faster than in the system to keep the run short;
    // each phase still far exceeds the synchroniser constraint.
    localparam int HALF = 32;
    localparam int SYNC = 2;

    typedef struct {
        logic        err;
        logic [31:0] digits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ser_sclk;
    logic        ser_en;
    logic        ser_sdi;
    logic [31:0] digits;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  seg_out;
    logic [3:0]  dig_sel;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #10 clk = ~clk;

    serial_digit_rx #(
        .SCAN_DIV (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ser_sclk    (ser_sclk),
        .ser_en      (ser_en),
        .ser_sdi     (ser_sdi),
        .digits      (digits),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .seg_out     (seg_out),
        .dig_sel     (dig_sel)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_frame(input logic err, input logic [31:0] d);
        exp_t e;
        e.err    = err;
        e.digits = d;
        exp_q.push_back(e);
    endtask

    // Pin enable fall to status pulse, counted in clocks.
    task automatic measure_latency();
        int n = 0;
        while (!(frame_valid || frame_err) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(SYNC + 2));
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits,
                              input bit drop_last);
        ser_en = 1'b1;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            ser_sdi  = (i < 32) ? data[31-i] : 1'b0;
            ser_sclk = 1'b0;
            wait_clk(HALF);
            ser_sclk = 1'b1;
            if (drop_last && i == nbits - 1) begin
                ser_en = 1'b0;
                measure_latency();
            end
            wait_clk(HALF);
        end
        ser_sclk = 1'b0;
        wait_clk(HALF);
        if (!drop_last) begin
            ser_en = 1'b0;
            measure_latency();
        end
        wait_clk(4 * HALF);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_digits"}, digits, 32'h0);
        check({tag, "_valid"}, 32'(frame_valid), 32'h0);
        check({tag, "_err"}, 32'(frame_err), 32'h0);
        check({tag, "_seg"}, 32'(seg_out), 32'h0);
        check({tag, "_sel"}, 32'(dig_sel), 32'h1);
    endtask

    // Monitor: every status pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_valid || frame_err) begin
                if (frame_valid && frame_err) begin
                    n_checks++;
                    $display("FAIL both_pulses: valid=1 err=1 required exclusive");
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pulse: valid=%0d err=%0d digits=%h none expected",
                             frame_valid, frame_err, digits);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", 32'(frame_err), 32'(e.err));
                    check("digits", digits, e.digits);
                end
            end
        end
    end

    initial begin
        logic [3:0]  prev_sel;
        logic [31:0] scan_val;
        int          n;
        bit          found;

        rst_n    = 1'b0;
        ser_sclk = 1'b0;
        ser_en   = 1'b0;
        ser_sdi  = 1'b0;
        wait_clk(5);
        rst_n = 1'b1;
        check_reset_state("rst");

        // 1: nominal frame.
        expect_frame(1'b0, 32'hA5C3_0F81);
        send_frame(32'hA5C3_0F81, 32, 1'b0);

        // 2: valid frame then a 31-bit frame.
        expect_frame(1'b0, 32'h1234_5678);
        send_frame(32'h1234_5678, 32, 1'b0);
        expect_frame(1'b1, 32'h1234_5678);
        send_frame(32'hFFFF_FFFF, 31, 1'b0);

        // 3: 33-bit frame, then an empty enable pulse.
        expect_frame(1'b1, 32'h1234_5678);
        send_frame(32'hCAFE_F00D, 33, 1'b0);
        expect_frame(1'b1, 32'h1234_5678);
        ser_en = 1'b1;
        wait_clk(4 * HALF);
        ser_en = 1'b0;
        measure_latency();
        wait_clk(4 * HALF);

        // 5: display scan order with SCAN_DIV=4.
        scan_val = 32'h1122_3344;
        expect_frame(1'b0, scan_val);
        send_frame(scan_val, 32, 1'b0);
        prev_sel = dig_sel;
        found    = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found    = (prev_sel == 4'b1000) && (dig_sel == 4'b0001);
            prev_sel = dig_sel;
        end
        check("scan_sync", 32'(found), 32'h1);
        for (int i = 0; i < 16; i++) begin
            n = i / 4;
            check("scan_sel", 32'(dig_sel), 32'(4'b0001 << n));
            check("scan_seg", 32'(seg_out), 32'(scan_val[8*n +: 8]));
            @(negedge clk);
        end
        check("scan_wrap", 32'(dig_sel), 32'h1);

        // 4: reset at bit 16 aborts the frame; next frame is accepted.
        ser_en = 1'b1;
        wait_clk(HALF);
        for (int i = 0; i < 16; i++) begin
            ser_sdi  = ~ser_sdi;
            ser_sclk = 1'b0;
            wait_clk(HALF);
            ser_sclk = 1'b1;
            wait_clk(HALF);
        end
        ser_sclk = 1'b0;
        ser_en   = 1'b0;
        rst_n    = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        check_reset_state("midrst");
        wait_clk(4 * HALF);
        expect_frame(1'b0, 32'h0000_00FF);
        send_frame(32'h0000_00FF, 32, 1'b0);

        // 6: enable drops with the 32nd sclk rise, then a good frame.
        expect_frame(1'b1, 32'h0000_00FF);
        send_frame(32'h0F0F_0F0F, 32, 1'b1);
        expect_frame(1'b0, 32'hDEAD_BEEF);
        send_frame(32'hDEAD_BEEF, 32, 1'b0);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        check("drain", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
